// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS/CTRL bit positions, FSM state encoding and the decoded bus request.
package uart_tx_mmio_pkg;

  // Word index = addr[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_LVL_LSB = 8;

  localparam int CT_TX_EN  = 0;
  localparam int CT_IRQ_EN = 1;
  localparam int CT_FLUSH  = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [1:0]  word;
    logic [31:0] wdata;
  } bus_req_t;

  function automatic logic [31:0] status_word(input logic busy, input logic full,
                                              input logic empty, input logic ovf,
                                              input logic [7:0] level);
    logic [31:0] s;
    s = '0;
    s[ST_BUSY]                  = busy;
    s[ST_FULL]                  = full;
    s[ST_EMPTY]                 = empty;
    s[ST_OVF]                   = ovf;
    s[ST_LVL_LSB+7:ST_LVL_LSB]  = level;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output and a one-cycle flush.
// Flush takes priority over push/pop in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | (pop & ~empty)) & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// FIFO-buffered UART transmitter behind a small MMIO register file:
// TXDATA push, STATUS (sticky overflow), CTRL (tx_en, irq_en, flush pulse).
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        uart_busy,
  output logic        irq
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  bus_req_t req;
  logic     push_req, flush, ovf_clr, ovf_set, ctrl_wr;
  logic     unused_bits;

  assign req.wr    = sel & wr_en;
  assign req.rd    = sel & rd_en;
  assign req.word  = addr[3:2];
  assign req.wdata = wdata;
  assign unused_bits = ^{addr[1:0], wdata};

  assign push_req = req.wr & (req.word == REG_TXDATA);
  assign ctrl_wr  = req.wr & (req.word == REG_CTRL);
  assign flush    = ctrl_wr & req.wdata[CT_FLUSH];
  assign ovf_clr  = req.wr & (req.word == REG_STATUS) & req.wdata[ST_OVF];

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;
  logic [LW-1:0]        fifo_level;

  // A push colliding with a flush is dropped silently, not counted as overflow.
  assign fifo_push = push_req & ~flush & (~fifo_full | fifo_pop);
  assign ovf_set   = push_req & ~flush & fifo_full & ~fifo_pop;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush),
    .din   (req.wdata[DATA_BITS-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  tx_state_e            state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 tx_en_q, tx_en_d;
  logic                 irq_en_q, irq_en_d;
  logic                 ovf_q, ovf_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 baud_end, load, busy;

  assign baud_end  = (baud_q == BAUD_LAST);
  assign busy      = (state_q != S_IDLE) | ~fifo_empty;
  assign uart_busy = busy;
  assign irq       = fifo_empty & irq_en_q;
  assign tx        = tx_q;
  assign rdata     = rdata_q;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = tx_q;
    load     = 1'b0;
    fifo_pop = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_en_q & ~fifo_empty) load = 1'b1;
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else baud_d = baud_q + BW'(1);
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d    = shift_q[1];
          end
        end else baud_d = baud_q + BW'(1);
      end
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
        end else baud_d = baud_q + BW'(1);
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            // Chain straight into the next start bit when data is waiting.
            if (tx_en_q & ~fifo_empty) load = 1'b1;
            else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else bit_d = bit_q + 3'd1;
        end else baud_d = baud_q + BW'(1);
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (load) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_dout;
      par_d    = (^fifo_dout) ^ ODD;
      state_d  = S_START;
      baud_d   = '0;
      bit_d    = '0;
      tx_d     = 1'b0;
    end
  end

  always_comb begin
    tx_en_d  = tx_en_q;
    irq_en_d = irq_en_q;
    if (ctrl_wr) begin
      tx_en_d  = req.wdata[CT_TX_EN];
      irq_en_d = req.wdata[CT_IRQ_EN];
    end
    ovf_d   = ovf_set | (ovf_q & ~ovf_clr);
    rdata_d = rdata_q;
    if (req.rd) begin
      unique case (req.word)
        REG_STATUS: rdata_d = status_word(busy, fifo_full, fifo_empty, ovf_q, 8'(fifo_level));
        REG_CTRL:   rdata_d = {30'd0, irq_en_q, tx_en_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      tx_en_q  <= 1'b1;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      tx_en_q  <= tx_en_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
